// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared opcodes, geometry and argument-count lookup for the OLED SPI receiver
package oled_pkg;

   localparam int PAGES  = 8;
   localparam int COLS   = 128;
   localparam int ADDR_W = 10;

   localparam logic [7:0] COL_LO   = 8'h00;
   localparam logic [7:0] COL_HI   = 8'h10;
   localparam logic [7:0] SET_PAGE = 8'hB0;
   localparam logic [7:0] DISP_OFF = 8'hAE;
   localparam logic [7:0] DISP_ON  = 8'hAF;

   localparam logic [7:0] ARG1_CMDS [9] = '{8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                                             8'hD5, 8'hD9, 8'hDA, 8'hDB};
   localparam logic [7:0] ARG2_CMDS [2] = '{8'h21, 8'h22};

   typedef enum logic {ST_CMD, ST_ARG} rx_state_t;

   // Number of argument bytes that follow a command opcode; 0 for plain commands.
   function automatic logic [1:0] arg_count(input logic [7:0] op);
      logic [1:0] n;
      n = 2'd0;
      for (int i = 0; i < 9; i++)
         if (op == ARG1_CMDS[i]) n = 2'd1;
      for (int i = 0; i < 2; i++)
         if (op == ARG2_CMDS[i]) n = 2'd2;
      return n;
   endfunction

endpackage

// File: rtl/spi_rx_sync.sv
// rtl/spi_rx_sync.sv - pin synchronizers and sclk rising-edge detector
module spi_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic mosi,
   input  logic dc,
   input  logic oled_rst,
   output logic sclk_rise,
   output logic mosi_s,
   output logic dc_s,
   output logic oled_rst_s
);

   logic [SYNC_STAGES-1:0] sclk_ff;
   logic [SYNC_STAGES-1:0] mosi_ff;
   logic [SYNC_STAGES-1:0] dc_ff;
   logic [SYNC_STAGES-1:0] rst_ff;
   logic                   sclk_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_ff <= '0;
         mosi_ff <= '0;
         dc_ff   <= '0;
         rst_ff  <= '0;
         sclk_d  <= 1'b0;
      end else begin
         sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk};
         mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
         dc_ff   <= {dc_ff[SYNC_STAGES-2:0], dc};
         rst_ff  <= {rst_ff[SYNC_STAGES-2:0], oled_rst};
         sclk_d  <= sclk_ff[SYNC_STAGES-1];
      end
   end

   assign sclk_rise  = sclk_ff[SYNC_STAGES-1] & ~sclk_d;
   assign mosi_s     = mosi_ff[SYNC_STAGES-1];
   assign dc_s       = dc_ff[SYNC_STAGES-1];
   assign oled_rst_s = rst_ff[SYNC_STAGES-1];

endmodule

// File: rtl/oled_spi_rx.sv
// rtl/oled_spi_rx.sv - SPI byte receiver with SSD1306-style command decode and RAM write port
module oled_spi_rx
   import oled_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              oled_rst,
   input  logic              oled_sclk,
   input  logic              oled_mosi,
   input  logic              oled_dc,
   output logic              cmd_valid,
   output logic [7:0]        cmd_byte,
   output logic              cmd_is_arg,
   output logic              wren,
   output logic [ADDR_W-1:0] wraddress,
   output logic [7:0]        wrdata,
   output logic              display_on,
   output logic              frame_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic            sclk_rise, mosi_s, dc_s, oled_rst_s;
   logic [2:0]      bit_cnt;
   logic [6:0]      shreg;
   logic [TW-1:0]   tmo_cnt;
   logic [2:0]      page;
   logic [6:0]      col;
   logic [1:0]      args_left;
   rx_state_t       state;
   logic [7:0]      rx_byte;

   spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk       (oled_sclk),
      .mosi       (oled_mosi),
      .dc         (oled_dc),
      .oled_rst   (oled_rst),
      .sclk_rise  (sclk_rise),
      .mosi_s     (mosi_s),
      .dc_s       (dc_s),
      .oled_rst_s (oled_rst_s)
   );

   // The first seven bits live in shreg; the eighth is taken straight from mosi on dispatch.
   assign rx_byte = {shreg, mosi_s};

   always_ff @(posedge clk) begin
      if (!rst_n || !oled_rst_s) begin
         cmd_valid  <= 1'b0;
         cmd_byte   <= '0;
         cmd_is_arg <= 1'b0;
         wren       <= 1'b0;
         wraddress  <= '0;
         wrdata     <= '0;
         display_on <= 1'b0;
         frame_err  <= 1'b0;
         bit_cnt    <= '0;
         shreg      <= '0;
         tmo_cnt    <= '0;
         page       <= '0;
         col        <= '0;
         args_left  <= '0;
         state      <= ST_CMD;
      end else begin
         wren      <= 1'b0;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         if (sclk_rise) begin
            tmo_cnt <= '0;
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               if (dc_s) begin
                  wren      <= 1'b1;
                  wrdata    <= rx_byte;
                  wraddress <= {page, col};
                  col       <= col + 7'd1;
                  state     <= ST_CMD;
                  args_left <= '0;
               end else begin
                  cmd_valid  <= 1'b1;
                  cmd_byte   <= rx_byte;
                  cmd_is_arg <= (state == ST_ARG);
                  if (state == ST_ARG) begin
                     args_left <= args_left - 2'd1;
                     if (args_left == 2'd1)
                        state <= ST_CMD;
                  end else begin
                     if ((rx_byte & 8'hF0) == COL_LO)
                        col[3:0] <= rx_byte[3:0];
                     else if ((rx_byte & 8'hF0) == COL_HI)
                        col[6:4] <= rx_byte[2:0];
                     else if ((rx_byte & 8'hF8) == SET_PAGE)
                        page <= rx_byte[2:0];
                     else if (rx_byte == DISP_OFF)
                        display_on <= 1'b0;
                     else if (rx_byte == DISP_ON)
                        display_on <= 1'b1;
                     if (arg_count(rx_byte) != 2'd0) begin
                        state     <= ST_ARG;
                        args_left <= arg_count(rx_byte);
                     end
                  end
               end
            end
         end else if (bit_cnt != 3'd0) begin
            // A stalled partial byte is dropped; decode state is deliberately left alone.
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               bit_cnt   <= '0;
               shreg     <= '0;
               tmo_cnt   <= '0;
               frame_err <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt + TW'(1);
            end
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_oled_spi_rx.sv
// tb/tb_oled_spi_rx.sv - directed and random checks of oled_spi_rx against a byte-level model
module tb_oled_spi_rx;

   localparam int TIMEOUT = 1024;

   logic       clk = 1'b0;
   logic       rst_n, oled_rst, oled_sclk, oled_mosi, oled_dc;
   logic       cmd_valid, cmd_is_arg, wren, display_on, frame_err;
   logic [7:0] cmd_byte, wrdata;
   logic [9:0] wraddress;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int overlap_cnt = 0;

   logic [17:0] wq[$];
   logic [8:0]  cq[$];

   int  m_page, m_col, m_args;
   bit  m_disp;
   logic [9:0] last_addr;
   logic [7:0] last_data;
   logic       last_is_arg;

   oled_spi_rx #(.SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .oled_rst   (oled_rst),
      .oled_sclk  (oled_sclk),
      .oled_mosi  (oled_mosi),
      .oled_dc    (oled_dc),
      .cmd_valid  (cmd_valid),
      .cmd_byte   (cmd_byte),
      .cmd_is_arg (cmd_is_arg),
      .wren       (wren),
      .wraddress  (wraddress),
      .wrdata     (wrdata),
      .display_on (display_on),
      .frame_err  (frame_err)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (wren)      wq.push_back({wraddress, wrdata});
      if (cmd_valid) cq.push_back({cmd_is_arg, cmd_byte});
      if (frame_err) fe_cnt++;
      if (wren && cmd_valid) overlap_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
      for (int i = 7; i > 7 - n; i--) begin
         oled_mosi = b[i];
         oled_dc   = dc;
         oled_sclk = 1'b0;
         wait_clk(5);
         oled_sclk = 1'b1;
         wait_clk(5);
      end
      oled_sclk = 1'b0;
   endtask

   // Sends one byte and checks the single resulting event plus display state against the model.
   task automatic check_byte(input logic [7:0] b, input logic dc);
      logic [17:0] we;
      logic [8:0]  ce;
      send_bits(b, 8, dc);
      wait_clk(6);
      if (dc) begin
         chk("wren_count", wq.size(), 1);
         chk("cmd_count_on_data", cq.size(), 0);
         if (wq.size() > 0) begin
            we = wq.pop_front();
            last_addr = we[17:8];
            last_data = we[7:0];
            chk("wraddress", last_addr, m_page * 128 + m_col);
            chk("wrdata", last_data, b);
         end
         m_col  = (m_col + 1) % 128;
         m_args = 0;
      end else begin
         chk("cmd_count", cq.size(), 1);
         chk("wren_count_on_cmd", wq.size(), 0);
         if (cq.size() > 0) begin
            ce = cq.pop_front();
            last_is_arg = ce[8];
            chk("cmd_byte", ce[7:0], b);
            chk("cmd_is_arg", last_is_arg, (m_args > 0));
         end
         if (m_args > 0) begin
            m_args--;
         end else begin
            if (b < 8'h10)                        m_col = (m_col / 16) * 16 + (b % 16);
            else if (b < 8'h20)                   m_col = (b % 8) * 16 + (m_col % 16);
            else if (b >= 8'hB0 && b <= 8'hB7)    m_page = b - 8'hB0;
            else if (b == 8'hAE)                  m_disp = 1'b0;
            else if (b == 8'hAF)                  m_disp = 1'b1;
            case (b)
               8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: m_args = 1;
               8'h21, 8'h22: m_args = 2;
               default: ;
            endcase
         end
      end
      wq.delete();
      cq.delete();
      chk("display_on", display_on, m_disp);
   endtask

   initial begin
      int fe_base;
      logic [7:0] rb;
      logic       rdc;

      rst_n = 1'b0; oled_rst = 1'b1; oled_sclk = 1'b0; oled_mosi = 1'b0; oled_dc = 1'b0;
      m_page = 0; m_col = 0; m_args = 0; m_disp = 1'b0;
      wait_clk(4);
      @(negedge clk);
      chk("reset_outputs", {cmd_valid, cmd_byte, cmd_is_arg, wren, wraddress, wrdata, display_on, frame_err}, 0);
      rst_n = 1'b1;
      wait_clk(6);

      // page 3, col 0x25, one data byte
      check_byte(8'hB3, 1'b0);
      check_byte(8'h05, 1'b0);
      check_byte(8'h12, 1'b0);
      check_byte(8'hA5, 1'b1);
      chk("req035_addr", last_addr, 10'h1A5);
      chk("req035_data", last_data, 8'hA5);

      // column wrap from 127 stays on page 0
      check_byte(8'hB0, 1'b0);
      check_byte(8'h0F, 1'b0);
      check_byte(8'h17, 1'b0);
      check_byte(8'h11, 1'b1);
      chk("wrap_addr0", last_addr, 10'h07F);
      check_byte(8'h22, 1'b1);
      chk("wrap_addr1", last_addr, 10'h000);

      // argument byte is not decoded
      check_byte(8'h81, 1'b0);
      check_byte(8'h0F, 1'b0);
      chk("arg_flag", last_is_arg, 1'b1);
      check_byte(8'h44, 1'b1);
      chk("arg_col_kept", last_addr, 10'h001);

      // data inside an argument run returns to command state
      check_byte(8'h21, 1'b0);
      check_byte(8'h55, 1'b1);
      chk("arg_data_addr", last_addr, 10'h002);
      check_byte(8'h03, 1'b0);
      chk("after_arg_is_cmd", last_is_arg, 1'b0);
      check_byte(8'h66, 1'b1);
      chk("col_lo_after_arg", last_addr, 10'h003);

      // partial byte timeout
      fe_base = fe_cnt;
      send_bits(8'hFF, 5, 1'b0);
      wait_clk(TIMEOUT + 12);
      chk("frame_err_once", fe_cnt - fe_base, 1);
      chk("timeout_no_events", wq.size() + cq.size(), 0);
      check_byte(8'hAF, 1'b0);
      chk("disp_on_after_timeout", display_on, 1'b1);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         rb  = 8'($urandom_range(0, 255));
         rdc = 1'($urandom_range(0, 1));
         check_byte(rb, rdc);
      end

      // panel reset mid-byte
      check_byte(8'hAF, 1'b0);
      send_bits(8'hFF, 3, 1'b1);
      oled_rst = 1'b0;
      wait_clk(10);
      oled_rst = 1'b1;
      wait_clk(6);
      chk("panel_rst_disp", display_on, 1'b0);
      chk("panel_rst_no_events", wq.size() + cq.size(), 0);
      m_page = 0; m_col = 0; m_args = 0; m_disp = 1'b0;
      check_byte(8'h3C, 1'b1);
      chk("panel_rst_addr", last_addr, 10'h000);
      chk("panel_rst_data", last_data, 8'h3C);

      chk("no_overlap", overlap_cnt, 0);
      chk("frame_err_total", fe_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/oled_spi_rx.md
OLED_SPI_RX -- requirements
Module: oled_spi_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the input synchronizer depth (legal range 2..3).
REQ-002 Parameter TIMEOUT, default 1024, is the number of clk cycles without an sclk rising edge after which a partial byte is discarded.
REQ-003 clk  input  1  system clock, 50 MHz; the only clock.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 oled_rst  input  1  panel reset pin from the driver; active-low.
REQ-006 oled_sclk  input  1  SPI clock, asynchronous to clk, at most 5 MHz.
REQ-007 oled_mosi  input  1  SPI data, MSB first.
REQ-008 oled_dc  input  1  0 = command byte, 1 = data byte.
REQ-009 cmd_valid  output  1  one-cycle pulse: a command byte was received.
REQ-010 cmd_byte  output  8  received command byte; held until the next cmd_valid.
REQ-011 cmd_is_arg  output  1  qualifies cmd_valid: byte was an argument of a multi-byte command.
REQ-012 wren  output  1  one-cycle pulse: write wrdata to display RAM.
REQ-013 wraddress  output  10  RAM address, {page[2:0], col[6:0]}.
REQ-014 wrdata  output  8  display data byte, one vertical 8-pixel column.
REQ-015 display_on  output  1  level: last 0xAF/0xAE command received.
REQ-016 frame_err  output  1  one-cycle pulse: partial byte discarded on timeout.

Function
REQ-017 oled_sclk, oled_mosi, oled_dc and oled_rst shall each pass through a SYNC_STAGES flip-flop synchronizer; all logic shall use only the synchronized copies.
REQ-018 SPI mode 0: mosi shall be sampled on each synchronized sclk rising edge into an 8-bit shift register, MSB first, and a 3-bit counter shall increment.
REQ-019 On the 8th edge, dc shall be sampled together with the last bit; the byte shall be dispatched and the counter shall return to 0.
REQ-020 Outputs for a byte shall assert exactly 1 cycle after the 8th edge is detected, so pin-to-output latency is at most SYNC_STAGES+2 cycles.
REQ-021 A data byte (dc=1) shall assert wren, with wrdata set to the byte and wraddress set to {page,col}.
REQ-022 After each data write, col shall increment; the increment from 127 shall wrap col to 0 and page shall be unchanged.
REQ-023 Every command byte (dc=0) shall pulse cmd_valid; decoding shall apply only in state CMD, not in ARG.
REQ-024 Decode, in state CMD:
  0x00-0x0F sets col[3:0] = byte[3:0];
  0x10-0x1F sets col[6:4] = byte[2:0];
  0xB0-0xB7 sets page = byte[2:0];
  0xAE clears display_on;
  0xAF sets display_on;
  all other bytes change no state.
REQ-025 Argument FSM:
  CMD -> ARG with args_left=1 on 0x20, 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA or 0xDB;
  CMD -> ARG with args_left=2 on 0x21 or 0x22.
REQ-026 In state ARG, cmd_is_arg=1 and args_left shall decrement; ARG -> CMD when args_left reaches 0.
REQ-027 A data byte received in state ARG shall be written normally to RAM and shall force the FSM to CMD.
REQ-028 If the bit counter is nonzero and TIMEOUT cycles pass with no sclk rising edge, the partial byte shall be discarded, the counter cleared and frame_err pulsed; the FSM, page and col shall be unaffected.
REQ-029 Synchronized oled_rst=0 shall act like rst_n=0, except that display_on shall also be cleared; it shall take priority over a simultaneous byte completion.
REQ-030 wren and cmd_valid shall never assert in the same cycle.

Reset
REQ-031 On rst_n=0 at a clk edge, the block shall reset synchronously:
  all outputs 0;
  bit counter, shift register, timeout counter, page, col and args_left 0;
  FSM = CMD;
  synchronizer flops cleared, with the sclk flops set to 0 so that no false edge appears after reset.
REQ-032 A byte in flight at reset shall be discarded; reception shall resume on the next complete 8 edges.

Structure
REQ-033 Shared package oled_pkg shall hold the command opcodes (SET_PAGE 0xB0, COL_LO 0x00, COL_HI 0x10, DISP_OFF 0xAE, DISP_ON 0xAF, the arg-command list), plus PAGES=8, COLS=128 and the address width of 10.
REQ-034 One sub-module, spi_rx_sync, shall implement the synchronizers and the sclk rising-edge detector; the shift, decode and FSM logic shall live in oled_spi_rx.

Verification
REQ-035 Command 0xB3, then 0x05, then 0x12 with dc=0; then data 0xA5 with dc=1 -> one wren, wraddress=0x1A5 (page 3, col 0x25), wrdata=0xA5.
REQ-036 Page 0, col 127, then two data bytes 0x11 and 0x22 -> wren at 0x07F then 0x000, page still 0.
REQ-037 Command 0x81, then 0x0F -> cmd_valid twice, second with cmd_is_arg=1; col unchanged (not set to 0x0F).
REQ-038 Command 0x21 followed by data 0x55 -> wren at the current address, FSM back in CMD; next 0x03 sets col[3:0]=3.
REQ-039 Send 5 bits, stall TIMEOUT+1 cycles -> frame_err pulses once; next full byte 0xAF -> display_on=1.
REQ-040 Pull oled_rst low mid-byte for 10 cycles, then send data 0x3C -> wren at 0x000 with wrdata=0x3C; display_on=0.
